// File: rtl/triangle_loader.sv
// Triangle packet loader: parses A5 | count_hi | count_lo | payload | chk from a
// byte stream, assembles fixed-size triangle records and writes each one to the
// triangle memory. Commits the triangle count only when the checksum matches.
module triangle_loader #(
  parameter int N_TRIS    = 968,
  parameter int TRI_BYTES = 42,
  parameter int ADDR_W    = $clog2(N_TRIS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [8*TRI_BYTES-1:0] mem_wdata,
  output logic [15:0]            tri_count,
  output logic                   load_done,
  output logic                   load_error,
  output logic                   busy
);

  localparam int          BYTE_W    = (TRI_BYTES > 1) ? $clog2(TRI_BYTES) : 1;
  localparam logic [7:0]  SYNC      = 8'hA5;
  localparam logic [15:0] MAX_COUNT = 16'(N_TRIS);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(TRI_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    CNT_HI,
    CNT_LO,
    PAYLOAD,
    CHECK,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         count_q, count_d;
  logic [7:0]          xor_q, xor_d;
  logic [BYTE_W-1:0]   byte_idx_q, byte_idx_d;
  logic [15:0]         rec_q, rec_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [15:0]         tri_count_q, tri_count_d;
  logic                load_done_q, load_done_d;
  logic                load_error_q, load_error_d;
  logic                busy_q;
  logic                accept;
  logic                payload_take;
  logic [15:0]         new_count;

  // The stream stalls during the commit cycle and while a record write is on the bus,
  // which keeps mem_wdata/mem_addr stable for the whole write strobe.
  assign in_ready     = (state_q != DONE) && !mem_we_q;
  assign accept       = in_valid && in_ready;
  assign payload_take = accept && (state_q == PAYLOAD);
  assign new_count    = {count_q[15:8], in_data};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and next-value logic for the packet parser
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    xor_d        = xor_q;
    byte_idx_d   = byte_idx_q;
    rec_d        = rec_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_we_q ? mem_addr_q + ADDR_W'(1) : mem_addr_q;
    tri_count_d  = tri_count_q;
    load_done_d  = 1'b0;
    load_error_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept && in_data == SYNC) begin
          state_d    = CNT_HI;
          xor_d      = '0;
          byte_idx_d = '0;
          rec_d      = '0;
          mem_addr_d = '0;
        end
      end

      CNT_HI: begin
        if (accept) begin
          count_d = {in_data, 8'h00};
          xor_d   = xor_q ^ in_data;
          state_d = CNT_LO;
        end
      end

      CNT_LO: begin
        if (accept) begin
          count_d = new_count;
          xor_d   = xor_q ^ in_data;
          if (new_count > MAX_COUNT) begin
            load_error_d = 1'b1;
            state_d      = IDLE;
          end else if (new_count == 16'd0) begin
            state_d = CHECK;
          end else begin
            state_d = PAYLOAD;
          end
        end
      end

      PAYLOAD: begin
        if (accept) begin
          xor_d = xor_q ^ in_data;
          if (byte_idx_q == LAST_BYTE) begin
            byte_idx_d = '0;
            mem_we_d   = 1'b1;
            rec_d      = rec_q + 16'd1;
            if (rec_q + 16'd1 == count_q) state_d = CHECK;
          end else begin
            byte_idx_d = byte_idx_q + BYTE_W'(1);
          end
        end
      end

      CHECK: begin
        if (accept) begin
          if (in_data == xor_q) begin
            state_d     = DONE;
            load_done_d = 1'b1;
            tri_count_d = count_q;
          end else begin
            load_error_d = 1'b1;
            state_d      = IDLE;
          end
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q      <= '0;
      xor_q        <= '0;
      byte_idx_q   <= '0;
      rec_q        <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      tri_count_q  <= '0;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      count_q      <= count_d;
      xor_q        <= xor_d;
      byte_idx_q   <= byte_idx_d;
      rec_q        <= rec_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      tri_count_q  <= tri_count_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
      busy_q       <= (state_d != IDLE);
    end
  end

  // One byte lane per record byte; byte k of a record lands in lane k
  for (genvar gi = 0; gi < TRI_BYTES; gi++) begin : g_rec_byte
    logic [7:0] lane_q;

    // Capture the stream byte when it is byte gi of the current record
    always_ff @(posedge clk) begin
      if (!rst_n)                                            lane_q <= '0;
      else if (payload_take && byte_idx_q == BYTE_W'(gi))    lane_q <= in_data;
    end

    assign mem_wdata[8*gi +: 8] = lane_q;
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign tri_count  = tri_count_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_triangle_loader.sv
// Testbench for triangle_loader: packets are built from a high-level description
// (count, record bytes, good/bad checksum) and the memory writes and pulses seen
// on the outputs are compared with what that description implies.
module tb_triangle_loader;

  localparam int N_TRIS   = 968;
  localparam int TB_BYTES = 42;
  localparam int ADDR_W   = $clog2(N_TRIS);

  typedef logic [8*TB_BYTES-1:0] rec_t;

  logic              clk;
  logic              rst_n;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  rec_t              mem_wdata;
  logic [15:0]       tri_count;
  logic              load_done;
  logic              load_error;
  logic              busy;

  triangle_loader #(
    .N_TRIS   (N_TRIS),
    .TRI_BYTES(TB_BYTES),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .tri_count (tri_count),
    .load_done (load_done),
    .load_error(load_error),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference expectations
  logic [7:0]  pkt[$];
  rec_t        exp_rec[$];
  int          exp_addr[$];
  int          exp_done;
  int          exp_err;
  logic [15:0] exp_tri;

  // Observed behaviour
  rec_t got_rec[$];
  int   got_addr[$];
  int   got_done;
  int   got_err;
  int   got_both;

  // Record every write strobe cycle and every pulse, sampled mid-cycle
  always @(negedge clk) begin
    if (mem_we) begin
      got_rec.push_back(mem_wdata);
      got_addr.push_back(int'(mem_addr));
    end
    if (load_done)  got_done++;
    if (load_error) got_err++;
    if (load_done && load_error) got_both++;
  end

  task automatic clear_scoreboard();
    exp_rec.delete(); exp_addr.delete(); exp_done = 0; exp_err = 0;
    got_rec.delete(); got_addr.delete(); got_done = 0; got_err = 0; got_both = 0;
  endtask

  // Build a packet and its expected effect. mode 0: byte i = i[7:0]; mode 1: random.
  task automatic build(input int cnt, input int mode, input bit bad_chk);
    logic [7:0] x, b;
    rec_t rr;
    pkt.delete();
    pkt.push_back(8'hA5);
    pkt.push_back(8'(cnt >> 8));
    pkt.push_back(8'(cnt));
    x = 8'(cnt >> 8) ^ 8'(cnt);
    if (cnt > N_TRIS) begin
      exp_err++;
      return;
    end
    for (int r = 0; r < cnt; r++) begin
      rr = '0;
      for (int k = 0; k < TB_BYTES; k++) begin
        b = (mode == 0) ? 8'(r * TB_BYTES + k) : 8'($urandom);
        rr[8*k +: 8] = b;
        pkt.push_back(b);
        x ^= b;
      end
      exp_rec.push_back(rr);
      exp_addr.push_back(r);
    end
    pkt.push_back(bad_chk ? ~x : x);
    if (bad_chk) exp_err++;
    else begin
      exp_done++;
      exp_tri = 16'(cnt);
    end
  endtask

  // Offer one byte with optional idle gaps; returns once it has been accepted
  task automatic push(input logic [7:0] b, input int gap_pct);
    int  waited;
    int  gaps;
    bit  acc;
    gaps = 0;
    while (gap_pct > 0 && $urandom_range(99) < gap_pct && gaps < 8) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      @(posedge clk); #1;
      gaps++;
    end
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    do begin
      acc = in_ready;
      @(posedge clk); #1;
      waited++;
    end while (!acc && waited < 100);
    if (!acc) begin
      total++; bad++;
      $display("FAIL push_timeout: byte %02h not accepted after %0d cycles, required acceptance", b, waited);
    end
    in_valid = 1'b0;
  endtask

  task automatic send(input int gap_pct, input int n_bytes);
    for (int i = 0; i < n_bytes && i < pkt.size(); i++) push(pkt[i], gap_pct);
  endtask

  task automatic settle();
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; exp_tri = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    total += 8;
    if (tri_count !== 16'd0) begin bad++; $display("FAIL reset_tri_count: got %0d need 0", tri_count); end
    if (mem_we !== 1'b0)     begin bad++; $display("FAIL reset_mem_we: got %b need 0", mem_we); end
    if (mem_addr !== '0)     begin bad++; $display("FAIL reset_mem_addr: got %0d need 0", mem_addr); end
    if (mem_wdata !== '0)    begin bad++; $display("FAIL reset_mem_wdata: got %h need 0", mem_wdata); end
    if (load_done !== 1'b0)  begin bad++; $display("FAIL reset_load_done: got %b need 0", load_done); end
    if (load_error !== 1'b0) begin bad++; $display("FAIL reset_load_error: got %b need 0", load_error); end
    if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy: got %b need 0", busy); end
    if (in_ready !== 1'b1)   begin bad++; $display("FAIL reset_in_ready: got %b need 1", in_ready); end
    $display("txn reset: outputs checked");
  endtask

  task automatic test_good_load();
    clear_scoreboard();
    build(2, 0, 1'b0);
    send(0, pkt.size());
    settle();
    total++;
    if (got_addr.size() !== exp_addr.size()) begin
      bad++; $display("FAIL good_write_count: got %0d need %0d", got_addr.size(), exp_addr.size());
    end else begin
      foreach (exp_addr[i]) begin
        total += 2;
        if (got_addr[i] !== exp_addr[i]) begin bad++; $display("FAIL good_addr[%0d]: got %0d need %0d", i, got_addr[i], exp_addr[i]); end
        if (got_rec[i] !== exp_rec[i]) begin bad++; $display("FAIL good_rec[%0d]: got %h need %h", i, got_rec[i], exp_rec[i]); end
      end
    end
    total += 4;
    if (tri_count !== exp_tri) begin bad++; $display("FAIL good_tri_count: got %0d need %0d", tri_count, exp_tri); end
    if (got_done !== exp_done) begin bad++; $display("FAIL good_done: got %0d need %0d", got_done, exp_done); end
    if (got_err !== exp_err)   begin bad++; $display("FAIL good_error: got %0d need %0d", got_err, exp_err); end
    if (got_both !== 0)        begin bad++; $display("FAIL good_both: got %0d need 0", got_both); end
    $display("txn good_load: writes=%0d done=%0d err=%0d tri=%0d", got_addr.size(), got_done, got_err, tri_count);
  endtask

  task automatic test_bad_checksum();
    clear_scoreboard();
    build(2, 0, 1'b1);
    send(0, pkt.size());
    settle();
    total++;
    if (got_addr.size() !== exp_addr.size()) begin
      bad++; $display("FAIL badchk_write_count: got %0d need %0d", got_addr.size(), exp_addr.size());
    end else begin
      foreach (exp_addr[i]) begin
        total += 2;
        if (got_addr[i] !== exp_addr[i]) begin bad++; $display("FAIL badchk_addr[%0d]: got %0d need %0d", i, got_addr[i], exp_addr[i]); end
        if (got_rec[i] !== exp_rec[i]) begin bad++; $display("FAIL badchk_rec[%0d]: got %h need %h", i, got_rec[i], exp_rec[i]); end
      end
    end
    total += 3;
    if (tri_count !== exp_tri) begin bad++; $display("FAIL badchk_tri_count: got %0d need %0d", tri_count, exp_tri); end
    if (got_done !== exp_done) begin bad++; $display("FAIL badchk_done: got %0d need %0d", got_done, exp_done); end
    if (got_err !== exp_err)   begin bad++; $display("FAIL badchk_error: got %0d need %0d", got_err, exp_err); end
    $display("txn bad_checksum: writes=%0d done=%0d err=%0d tri=%0d", got_addr.size(), got_done, got_err, tri_count);
  endtask

  task automatic test_count_zero();
    clear_scoreboard();
    build(0, 0, 1'b0);
    send(0, pkt.size());
    settle();
    total += 4;
    if (got_addr.size() !== 0) begin bad++; $display("FAIL zero_writes: got %0d need 0", got_addr.size()); end
    if (tri_count !== exp_tri) begin bad++; $display("FAIL zero_tri_count: got %0d need %0d", tri_count, exp_tri); end
    if (got_done !== exp_done) begin bad++; $display("FAIL zero_done: got %0d need %0d", got_done, exp_done); end
    if (got_err !== exp_err)   begin bad++; $display("FAIL zero_error: got %0d need %0d", got_err, exp_err); end
    $display("txn count_zero: writes=%0d done=%0d err=%0d tri=%0d", got_addr.size(), got_done, got_err, tri_count);
  endtask

  task automatic test_oversize();
    logic [7:0] j;
    clear_scoreboard();
    build(N_TRIS + 1, 0, 1'b0);
    send(0, 3);
    total += 2;
    if (load_error !== 1'b1) begin bad++; $display("FAIL oversize_error_timing: got %b need 1", load_error); end
    if (busy !== 1'b0)       begin bad++; $display("FAIL oversize_busy: got %b need 0", busy); end
    for (int i = 0; i < 60; i++) begin
      j = 8'($urandom);
      if (j == 8'hA5) j = 8'h5A;
      push(j, 0);
    end
    settle();
    total += 5;
    if (got_addr.size() !== 0) begin bad++; $display("FAIL oversize_writes: got %0d need 0", got_addr.size()); end
    if (tri_count !== exp_tri) begin bad++; $display("FAIL oversize_tri_count: got %0d need %0d", tri_count, exp_tri); end
    if (got_done !== exp_done) begin bad++; $display("FAIL oversize_done: got %0d need %0d", got_done, exp_done); end
    if (got_err !== exp_err)   begin bad++; $display("FAIL oversize_error: got %0d need %0d", got_err, exp_err); end
    if (busy !== 1'b0)         begin bad++; $display("FAIL oversize_junk_busy: got %b need 0", busy); end
    $display("txn oversize: writes=%0d done=%0d err=%0d tri=%0d", got_addr.size(), got_done, got_err, tri_count);
  endtask

  task automatic test_gaps_and_junk();
    clear_scoreboard();
    push(8'h00, 30); push(8'hFF, 30); push(8'h13, 30);
    build(2, 0, 1'b0);
    send(40, pkt.size());
    settle();
    total++;
    if (got_addr.size() !== exp_addr.size()) begin
      bad++; $display("FAIL gaps_write_count: got %0d need %0d", got_addr.size(), exp_addr.size());
    end else begin
      foreach (exp_addr[i]) begin
        total += 2;
        if (got_addr[i] !== exp_addr[i]) begin bad++; $display("FAIL gaps_addr[%0d]: got %0d need %0d", i, got_addr[i], exp_addr[i]); end
        if (got_rec[i] !== exp_rec[i]) begin bad++; $display("FAIL gaps_rec[%0d]: got %h need %h", i, got_rec[i], exp_rec[i]); end
      end
    end
    total += 3;
    if (tri_count !== exp_tri) begin bad++; $display("FAIL gaps_tri_count: got %0d need %0d", tri_count, exp_tri); end
    if (got_done !== exp_done) begin bad++; $display("FAIL gaps_done: got %0d need %0d", got_done, exp_done); end
    if (got_err !== exp_err)   begin bad++; $display("FAIL gaps_error: got %0d need %0d", got_err, exp_err); end
    $display("txn gaps_and_junk: writes=%0d done=%0d err=%0d tri=%0d", got_addr.size(), got_done, got_err, tri_count);
  endtask

  task automatic test_reset_mid_packet();
    clear_scoreboard();
    build(2, 1, 1'b0);
    // 50 payload bytes complete record 0 only; the packet never finishes
    while (exp_rec.size() > 1) begin
      void'(exp_rec.pop_back());
      void'(exp_addr.pop_back());
    end
    exp_done = 0;
    send(20, 3 + 50);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_tri = 16'd0;
    total += 8;
    if (tri_count !== 16'd0) begin bad++; $display("FAIL midrst_tri_count: got %0d need 0", tri_count); end
    if (mem_we !== 1'b0)     begin bad++; $display("FAIL midrst_mem_we: got %b need 0", mem_we); end
    if (mem_addr !== '0)     begin bad++; $display("FAIL midrst_mem_addr: got %0d need 0", mem_addr); end
    if (mem_wdata !== '0)    begin bad++; $display("FAIL midrst_mem_wdata: got %h need 0", mem_wdata); end
    if (busy !== 1'b0)       begin bad++; $display("FAIL midrst_busy: got %b need 0", busy); end
    if (in_ready !== 1'b1)   begin bad++; $display("FAIL midrst_in_ready: got %b need 1", in_ready); end
    if (got_addr.size() !== 1) begin bad++; $display("FAIL midrst_writes: got %0d need 1", got_addr.size()); end
    if (got_done !== 0 || got_err !== 0) begin
      bad++; $display("FAIL midrst_pulses: got done=%0d err=%0d need 0/0", got_done, got_err);
    end
    $display("txn reset_mid_packet: writes=%0d done=%0d err=%0d", got_addr.size(), got_done, got_err);

    clear_scoreboard();
    build(1, 1, 1'b0);
    send(20, pkt.size());
    settle();
    total += 5;
    if (got_addr.size() !== 1) begin
      bad++; $display("FAIL after_rst_writes: got %0d need 1", got_addr.size());
    end else begin
      if (got_addr[0] !== 0)          begin bad++; $display("FAIL after_rst_addr: got %0d need 0", got_addr[0]); end
      if (got_rec[0] !== exp_rec[0])  begin bad++; $display("FAIL after_rst_rec: got %h need %h", got_rec[0], exp_rec[0]); end
    end
    if (tri_count !== 16'd1)   begin bad++; $display("FAIL after_rst_tri_count: got %0d need 1", tri_count); end
    if (got_done !== exp_done) begin bad++; $display("FAIL after_rst_done: got %0d need %0d", got_done, exp_done); end
    if (got_err !== 0)         begin bad++; $display("FAIL after_rst_error: got %0d need 0", got_err); end
    $display("txn after_reset_load: writes=%0d done=%0d tri=%0d", got_addr.size(), got_done, tri_count);
  endtask

  task automatic test_back_to_back();
    int cnt;
    bit bchk;
    logic [7:0] j;
    for (int p = 0; p < 6; p++) begin
      clear_scoreboard();
      cnt  = int'($urandom_range(0, 3));
      bchk = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
        j = 8'($urandom);
        if (j == 8'hA5) j = 8'h00;
        push(j, 25);
      end
      build(cnt, 1, bchk);
      send(25, pkt.size());
      settle();
      total++;
      if (got_addr.size() !== exp_addr.size()) begin
        bad++; $display("FAIL rand%0d_write_count: got %0d need %0d", p, got_addr.size(), exp_addr.size());
      end else begin
        foreach (exp_addr[i]) begin
          total += 2;
          if (got_addr[i] !== exp_addr[i]) begin bad++; $display("FAIL rand%0d_addr[%0d]: got %0d need %0d", p, i, got_addr[i], exp_addr[i]); end
          if (got_rec[i] !== exp_rec[i]) begin bad++; $display("FAIL rand%0d_rec[%0d]: got %h need %h", p, i, got_rec[i], exp_rec[i]); end
        end
      end
      total += 4;
      if (tri_count !== exp_tri) begin bad++; $display("FAIL rand%0d_tri_count: got %0d need %0d", p, tri_count, exp_tri); end
      if (got_done !== exp_done) begin bad++; $display("FAIL rand%0d_done: got %0d need %0d", p, got_done, exp_done); end
      if (got_err !== exp_err)   begin bad++; $display("FAIL rand%0d_error: got %0d need %0d", p, got_err, exp_err); end
      if (got_both !== 0)        begin bad++; $display("FAIL rand%0d_both: got %0d need 0", p, got_both); end
      $display("txn random%0d: count=%0d badchk=%0d writes=%0d done=%0d err=%0d tri=%0d",
               p, cnt, bchk, got_addr.size(), got_done, got_err, tri_count);
    end
  endtask

  initial begin
    clear_scoreboard();
    test_reset();
    test_good_load();
    test_bad_checksum();
    test_count_zero();
    test_oversize();
    test_gaps_and_junk();
    test_reset_mid_packet();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
